// File: rtl/axi_latency_shaper.sv
// AXI channel delayer: every beat on each of the five channels is released a
// programmable number of cycles after acceptance, with optional LFSR jitter.

package axi_latency_shaper_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;
endpackage

module axi_latency_shaper_chan #(
    parameter type         data_t     = logic,
    parameter int unsigned Depth      = 4,
    parameter int unsigned DelayWidth = 8,
    parameter bit          Jitter     = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DelayWidth:0]   cnt_i,
    input  logic [DelayWidth-1:0] delay_i,
    input  logic                  jitter_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  data_t                 data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output data_t                 data_o,
    output logic                  busy_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = DelayWidth + 1;

    typedef logic [PtrW-1:0] ptr_t;

    data_t           mem_q [Depth];
    logic [CntW-1:0] due_q [Depth];
    logic [Depth-1:0] occ_q, occ_d;
    logic [Depth-1:0] ripe_q, ripe_d;
    ptr_t            head_q, head_d;
    ptr_t            tail_q, tail_d;
    logic            presented_q, presented_d;
    logic            push, pop, releasable, gate;

    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == ptr_t'(Depth - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Tail slot occupied means every slot is occupied: no fall-through on pop.
    assign ready_o    = !occ_q[tail_q] && !rst_i;
    assign push       = valid_i && ready_o;
    assign releasable = occ_q[head_q] && (ripe_q[head_q] || (cnt_i == due_q[head_q]));
    assign gate       = Jitter ? jitter_i : 1'b1;
    assign valid_o    = !rst_i && releasable && (presented_q || gate);
    assign pop        = valid_o && ready_i;
    assign data_o     = mem_q[head_q];
    assign busy_o     = |occ_q;

    always_comb begin
        occ_d       = occ_q;
        ripe_d      = ripe_q;
        head_d      = head_q;
        tail_d      = tail_q;
        presented_d = presented_q;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (occ_q[ptr_t'(i)] && (cnt_i == due_q[ptr_t'(i)])) begin
                ripe_d[ptr_t'(i)] = 1'b1;
            end
        end
        if (pop) begin
            occ_d[head_q]  = 1'b0;
            ripe_d[head_q] = 1'b0;
            head_d         = ptr_inc(head_q);
            presented_d    = 1'b0;
        end else if (valid_o) begin
            presented_d = 1'b1;
        end
        if (push) begin
            occ_d[tail_q]  = 1'b1;
            ripe_d[tail_q] = 1'b0;
            tail_d         = ptr_inc(tail_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q       <= '0;
            ripe_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            presented_q <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            ripe_q      <= ripe_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            presented_q <= presented_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[tail_q] <= data_i;
            due_q[tail_q] <= cnt_i + {1'b0, delay_i} + CntW'(1);
        end
    end
endmodule

module axi_latency_shaper #(
    parameter type         aw_chan_t  = axi_latency_shaper_pkg::aw_chan_t,
    parameter type         w_chan_t   = axi_latency_shaper_pkg::w_chan_t,
    parameter type         b_chan_t   = axi_latency_shaper_pkg::b_chan_t,
    parameter type         ar_chan_t  = axi_latency_shaper_pkg::ar_chan_t,
    parameter type         r_chan_t   = axi_latency_shaper_pkg::r_chan_t,
    parameter type         req_t      = axi_latency_shaper_pkg::req_t,
    parameter type         resp_t     = axi_latency_shaper_pkg::resp_t,
    parameter int unsigned Depth      = 4,
    parameter int unsigned DelayWidth = 8,
    parameter bit          JitterIn   = 1'b0,
    parameter bit          JitterOut  = 1'b0,
    parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DelayWidth-1:0] delay_in_i,
    input  logic [DelayWidth-1:0] delay_out_i,
    input  req_t                  slv_req_i,
    output resp_t                 slv_resp_o,
    output req_t                  mst_req_o,
    input  resp_t                 mst_resp_i,
    output logic                  busy_o
);
    localparam int unsigned CntW = DelayWidth + 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [4:0]      busy;

    aw_chan_t aw_data;
    w_chan_t  w_data;
    b_chan_t  b_data;
    ar_chan_t ar_data;
    r_chan_t  r_data;
    logic aw_ready, w_ready, b_ready, ar_ready, r_ready;
    logic aw_valid, w_valid, b_valid, ar_valid, r_valid;

    // One extra counter bit keeps a 2^DelayWidth delay from aliasing across wrap.
    assign cnt_d  = cnt_q + CntW'(1);
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            lfsr_q <= LfsrSeed;
        end else begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
        end
    end

    axi_latency_shaper_chan #(
        .data_t(aw_chan_t), .Depth(Depth), .DelayWidth(DelayWidth), .Jitter(JitterIn)
    ) i_aw (
        .clk_i(clk_i), .rst_i(rst_i), .cnt_i(cnt_q), .delay_i(delay_in_i),
        .jitter_i(lfsr_q[0]),
        .valid_i(slv_req_i.aw_valid), .ready_o(aw_ready), .data_i(slv_req_i.aw),
        .valid_o(aw_valid), .ready_i(mst_resp_i.aw_ready), .data_o(aw_data),
        .busy_o(busy[0])
    );

    axi_latency_shaper_chan #(
        .data_t(w_chan_t), .Depth(Depth), .DelayWidth(DelayWidth), .Jitter(JitterIn)
    ) i_w (
        .clk_i(clk_i), .rst_i(rst_i), .cnt_i(cnt_q), .delay_i(delay_in_i),
        .jitter_i(lfsr_q[1]),
        .valid_i(slv_req_i.w_valid), .ready_o(w_ready), .data_i(slv_req_i.w),
        .valid_o(w_valid), .ready_i(mst_resp_i.w_ready), .data_o(w_data),
        .busy_o(busy[1])
    );

    axi_latency_shaper_chan #(
        .data_t(b_chan_t), .Depth(Depth), .DelayWidth(DelayWidth), .Jitter(JitterOut)
    ) i_b (
        .clk_i(clk_i), .rst_i(rst_i), .cnt_i(cnt_q), .delay_i(delay_out_i),
        .jitter_i(lfsr_q[2]),
        .valid_i(mst_resp_i.b_valid), .ready_o(b_ready), .data_i(mst_resp_i.b),
        .valid_o(b_valid), .ready_i(slv_req_i.b_ready), .data_o(b_data),
        .busy_o(busy[2])
    );

    axi_latency_shaper_chan #(
        .data_t(ar_chan_t), .Depth(Depth), .DelayWidth(DelayWidth), .Jitter(JitterIn)
    ) i_ar (
        .clk_i(clk_i), .rst_i(rst_i), .cnt_i(cnt_q), .delay_i(delay_in_i),
        .jitter_i(lfsr_q[3]),
        .valid_i(slv_req_i.ar_valid), .ready_o(ar_ready), .data_i(slv_req_i.ar),
        .valid_o(ar_valid), .ready_i(mst_resp_i.ar_ready), .data_o(ar_data),
        .busy_o(busy[3])
    );

    axi_latency_shaper_chan #(
        .data_t(r_chan_t), .Depth(Depth), .DelayWidth(DelayWidth), .Jitter(JitterOut)
    ) i_r (
        .clk_i(clk_i), .rst_i(rst_i), .cnt_i(cnt_q), .delay_i(delay_out_i),
        .jitter_i(lfsr_q[4]),
        .valid_i(mst_resp_i.r_valid), .ready_o(r_ready), .data_i(mst_resp_i.r),
        .valid_o(r_valid), .ready_i(slv_req_i.r_ready), .data_o(r_data),
        .busy_o(busy[4])
    );

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw       = aw_data;
        mst_req_o.aw_valid = aw_valid;
        mst_req_o.w        = w_data;
        mst_req_o.w_valid  = w_valid;
        mst_req_o.ar       = ar_data;
        mst_req_o.ar_valid = ar_valid;
        mst_req_o.b_ready  = b_ready;
        mst_req_o.r_ready  = r_ready;
    end

    always_comb begin
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.b        = b_data;
        slv_resp_o.b_valid  = b_valid;
        slv_resp_o.r        = r_data;
        slv_resp_o.r_valid  = r_valid;
    end

    assign busy_o = |busy;
endmodule

// File: tb/tb_axi_latency_shaper.sv
// Directed bench for axi_latency_shaper: latency, pipelining, backpressure,
// delay sampling, maximum delay and jittered random traffic with mid-stream reset.
module tb_axi_latency_shaper;
    import axi_latency_shaper_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, rst_j = 1'b1;
    logic [7:0] dly_in = '0, dly_out = '0, dly_in_j = '0, dly_out_j = '0;
    req_t       req = '0, req_j = '0, mst_req, mst_req_j;
    resp_t      resp = '0, resp_j = '0, slv_resp, slv_resp_j;
    logic       busy, busy_j;
    int         total = 0, bad = 0;
    longint     cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    axi_latency_shaper #(
        .Depth(4), .DelayWidth(8), .JitterIn(1'b0), .JitterOut(1'b0), .LfsrSeed(16'hACE1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .delay_in_i(dly_in), .delay_out_i(dly_out),
        .slv_req_i(req), .slv_resp_o(slv_resp), .mst_req_o(mst_req),
        .mst_resp_i(resp), .busy_o(busy)
    );

    axi_latency_shaper #(
        .Depth(4), .DelayWidth(8), .JitterIn(1'b1), .JitterOut(1'b0), .LfsrSeed(16'hACE1)
    ) dut_j (
        .clk_i(clk), .rst_i(rst_j), .delay_in_i(dly_in_j), .delay_out_i(dly_out_j),
        .slv_req_i(req_j), .slv_resp_o(slv_resp_j), .mst_req_o(mst_req_j),
        .mst_resp_i(resp_j), .busy_o(busy_j)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(); sample();
        total++;
        if ({slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready, mst_req.b_ready, mst_req.r_ready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_readys got=%b exp=00000",
                     {slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready, mst_req.b_ready, mst_req.r_ready});
        end
        total++;
        if ({mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid, slv_resp.b_valid, slv_resp.r_valid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_valids got=%b exp=00000",
                     {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid, slv_resp.b_valid, slv_resp.r_valid});
        end
        total++;
        if ({busy, busy_j} !== 2'b00) begin
            bad++; $display("FAIL reset_busy got=%b exp=00", {busy, busy_j});
        end
        step(); rst = 1'b0; rst_j = 1'b0; sample();
        total++;
        if ({slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready, mst_req.b_ready, mst_req.r_ready} !== 5'b11111) begin
            bad++;
            $display("FAIL post_reset_readys got=%b exp=11111",
                     {slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready, mst_req.b_ready, mst_req.r_ready});
        end
    endtask

    task automatic test_delay0();
        aw_chan_t exp_aw;
        exp_aw = aw_chan_t'{id: 4'h3, addr: 32'h1000_0040, len: 8'd7};
        dly_in = 8'd0;
        resp.aw_ready = 1'b0;
        step(); req.aw = exp_aw; req.aw_valid = 1'b1; sample();
        total++;
        if ({slv_resp.aw_ready, mst_req.aw_valid, busy} !== 3'b100) begin
            bad++; $display("FAIL d0_accept got rdy/vld/busy=%b exp=100", {slv_resp.aw_ready, mst_req.aw_valid, busy});
        end
        step(); req.aw_valid = 1'b0; req.aw = '0; sample();
        total++;
        if ({mst_req.aw_valid, busy} !== 2'b11) begin
            bad++; $display("FAIL d0_release got vld/busy=%b exp=11", {mst_req.aw_valid, busy});
        end
        total++;
        if (mst_req.aw !== exp_aw) begin
            bad++; $display("FAIL d0_payload got=%h exp=%h", mst_req.aw, exp_aw);
        end
        step(); sample();
        total++;
        if ({mst_req.aw_valid, busy, mst_req.aw == exp_aw} !== 3'b111) begin
            bad++; $display("FAIL d0_hold got vld/busy/same=%b exp=111", {mst_req.aw_valid, busy, mst_req.aw == exp_aw});
        end
        step(); resp.aw_ready = 1'b1; sample();
        total++;
        if (mst_req.aw_valid !== 1'b1) begin
            bad++; $display("FAIL d0_handshake got=%b exp=1", mst_req.aw_valid);
        end
        step(); resp.aw_ready = 1'b0; sample();
        total++;
        if ({mst_req.aw_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL d0_drain got vld/busy=%b exp=00", {mst_req.aw_valid, busy});
        end
    endtask

    task automatic test_pipeline();
        logic exp_v;
        dly_in = 8'd5;
        resp.w_ready = 1'b1;
        for (int rel = 0; rel <= 10; rel++) begin
            step();
            if (rel < 4) begin
                req.w_valid = 1'b1;
                req.w = w_chan_t'{data: 32'hCAFE_0000 + 32'(rel), strb: 4'hF, last: (rel == 3)};
            end else begin
                req.w_valid = 1'b0;
            end
            sample();
            if (rel < 4) begin
                total++;
                if (slv_resp.w_ready !== 1'b1) begin
                    bad++; $display("FAIL pipe_w_ready rel=%0d got=%b exp=1", rel, slv_resp.w_ready);
                end
            end
            exp_v = (rel >= 6) && (rel <= 9);
            total++;
            if (mst_req.w_valid !== exp_v) begin
                bad++; $display("FAIL pipe_w_valid rel=%0d got=%b exp=%b", rel, mst_req.w_valid, exp_v);
            end
            if (exp_v) begin
                total++;
                if (mst_req.w.data !== 32'hCAFE_0000 + 32'(rel - 6)) begin
                    bad++; $display("FAIL pipe_w_data rel=%0d got=%h exp=%h", rel, mst_req.w.data, 32'hCAFE_0000 + 32'(rel - 6));
                end
            end
        end
        resp.w_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic exp_v, exp_r;
        int   idx;
        dly_in = 8'd0;
        for (int rel = 0; rel <= 10; rel++) begin
            step();
            req.w_valid = (rel <= 6);
            req.w = w_chan_t'{data: 32'hBEEF_0000 + 32'((rel < 4) ? rel : 4), strb: 4'h3, last: 1'b1};
            resp.w_ready = (rel >= 5);
            sample();
            if (rel <= 6) begin
                exp_r = (rel <= 3) || (rel == 6);
                total++;
                if (slv_resp.w_ready !== exp_r) begin
                    bad++; $display("FAIL bp_w_ready rel=%0d got=%b exp=%b", rel, slv_resp.w_ready, exp_r);
                end
            end
            exp_v = (rel >= 1) && (rel <= 9);
            total++;
            if (mst_req.w_valid !== exp_v) begin
                bad++; $display("FAIL bp_w_valid rel=%0d got=%b exp=%b", rel, mst_req.w_valid, exp_v);
            end
            if (exp_v) begin
                idx = (rel <= 5) ? 0 : rel - 5;
                total++;
                if (mst_req.w.data !== 32'hBEEF_0000 + 32'(idx)) begin
                    bad++; $display("FAIL bp_w_data rel=%0d got=%h exp=%h", rel, mst_req.w.data, 32'hBEEF_0000 + 32'(idx));
                end
            end
        end
        resp.w_ready = 1'b0;
        req.w_valid = 1'b0;
    endtask

    task automatic test_delay_change();
        logic exp_v;
        int   idx;
        dly_out = 8'd3;
        req.r_ready = 1'b1;
        for (int rel = 0; rel <= 16; rel++) begin
            step();
            if (rel == 2) dly_out = 8'd10;
            resp.r_valid = (rel == 0) || (rel == 1) || (rel == 3) || (rel == 4);
            idx = (rel < 2) ? rel : rel - 1;
            resp.r = r_chan_t'{id: 4'(rel), data: 32'hD000_0000 + 32'(idx), resp: 2'b00, last: 1'b1};
            sample();
            if (resp.r_valid) begin
                total++;
                if (mst_req.r_ready !== 1'b1) begin
                    bad++; $display("FAIL dc_r_ready rel=%0d got=%b exp=1", rel, mst_req.r_ready);
                end
            end
            exp_v = (rel == 4) || (rel == 5) || (rel == 14) || (rel == 15);
            total++;
            if (slv_resp.r_valid !== exp_v) begin
                bad++; $display("FAIL dc_r_valid rel=%0d got=%b exp=%b", rel, slv_resp.r_valid, exp_v);
            end
            if (exp_v) begin
                idx = (rel == 4) ? 0 : (rel == 5) ? 1 : (rel == 14) ? 2 : 3;
                total++;
                if (slv_resp.r.data !== 32'hD000_0000 + 32'(idx)) begin
                    bad++; $display("FAIL dc_r_data rel=%0d got=%h exp=%h", rel, slv_resp.r.data, 32'hD000_0000 + 32'(idx));
                end
            end
        end
        resp.r_valid = 1'b0;
        req.r_ready = 1'b0;
    endtask

    task automatic test_max_delay(input logic [31:0] addr);
        ar_chan_t exp_ar;
        int       first;
        exp_ar = ar_chan_t'{id: 4'hA, addr: addr, len: 8'd1};
        dly_in = 8'd255;
        resp.ar_ready = 1'b1;
        step(); req.ar = exp_ar; req.ar_valid = 1'b1; sample();
        total++;
        if (slv_resp.ar_ready !== 1'b1) begin
            bad++; $display("FAIL max_ar_ready got=%b exp=1", slv_resp.ar_ready);
        end
        step(); req.ar_valid = 1'b0; req.ar = '0; dly_in = 8'd0;
        first = -1;
        for (int r = 1; r <= 300; r++) begin
            sample();
            if (mst_req.ar_valid) begin
                first = r;
                break;
            end
            step();
        end
        total++;
        if (first != 256) begin
            bad++; $display("FAIL max_latency got=%0d exp=256", first);
        end
        total++;
        if (mst_req.ar !== exp_ar) begin
            bad++; $display("FAIL max_payload got=%h exp=%h", mst_req.ar, exp_ar);
        end
        step(); sample();
        total++;
        if ({mst_req.ar_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL max_drain got vld/busy=%b exp=00", {mst_req.ar_valid, busy});
        end
        resp.ar_ready = 1'b0;
    endtask

    typedef struct {
        longint     t;
        logic [7:0] d;
        ar_chan_t   p;
    } exp_t;

    task automatic test_jitter();
        exp_t     q[$];
        exp_t     e;
        int       accepted = 0, handshakes = 0, n = 0;
        logic     acc_last = 1'b0, prev_v = 1'b0, prev_r = 1'b0, v;
        ar_chan_t prev_p = '0;
        while (accepted < 1000 && n < 30000) begin
            n++;
            step();
            if (!(req_j.ar_valid && !acc_last)) begin
                req_j.ar_valid = ($urandom_range(0, 1) == 1);
                req_j.ar = ar_chan_t'{id: 4'($urandom_range(0, 15)), addr: $urandom(), len: 8'($urandom_range(0, 255))};
            end
            resp_j.ar_ready = ($urandom_range(0, 3) != 0);
            dly_in_j = 8'($urandom_range(0, 7));
            sample();
            acc_last = req_j.ar_valid && slv_resp_j.ar_ready;
            if (acc_last) begin
                q.push_back('{t: cyc, d: dly_in_j, p: req_j.ar});
                accepted++;
            end
            v = mst_req_j.ar_valid;
            if (prev_v && !prev_r) begin
                total++;
                if (!v || mst_req_j.ar !== prev_p) begin
                    bad++; $display("FAIL jit_hold cyc=%0d got vld=%b p=%h exp vld=1 p=%h", cyc, v, mst_req_j.ar, prev_p);
                end
            end
            if (v && resp_j.ar_ready) begin
                handshakes++;
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL jit_spurious cyc=%0d got=%h exp=none", cyc, mst_req_j.ar);
                end else begin
                    e = q.pop_front();
                    if (mst_req_j.ar !== e.p) begin
                        bad++; $display("FAIL jit_order cyc=%0d got=%h exp=%h", cyc, mst_req_j.ar, e.p);
                    end
                    total++;
                    if (cyc - e.t < longint'(e.d) + 1) begin
                        bad++; $display("FAIL jit_early cyc=%0d got lat=%0d exp>=%0d", cyc, cyc - e.t, e.d + 1);
                    end
                end
            end
            prev_v = v;
            prev_r = resp_j.ar_ready;
            prev_p = mst_req_j.ar;
        end
        total++;
        if (accepted < 1000) begin
            bad++; $display("FAIL jit_timeout got=%0d exp=1000", accepted);
        end
        total++;
        if (handshakes == 0) begin
            bad++; $display("FAIL jit_no_release got=0 exp>0");
        end
        // Reset while at least the last accepted beat is still buffered.
        step(); rst_j = 1'b1; sample();
        total++;
        if ({slv_resp_j.aw_ready, slv_resp_j.w_ready, slv_resp_j.ar_ready, mst_req_j.b_ready, mst_req_j.r_ready,
             mst_req_j.aw_valid, mst_req_j.w_valid, mst_req_j.ar_valid, slv_resp_j.b_valid, slv_resp_j.r_valid} !== 10'b0) begin
            bad++; $display("FAIL jit_rst_handshake got=%b exp=0000000000",
                {slv_resp_j.aw_ready, slv_resp_j.w_ready, slv_resp_j.ar_ready, mst_req_j.b_ready, mst_req_j.r_ready,
                 mst_req_j.aw_valid, mst_req_j.w_valid, mst_req_j.ar_valid, slv_resp_j.b_valid, slv_resp_j.r_valid});
        end
        total++;
        if (busy_j !== 1'b1) begin
            bad++; $display("FAIL jit_busy_before_edge got=%b exp=1", busy_j);
        end
        step(); sample();
        total++;
        if ({busy_j, mst_req_j.ar_valid, slv_resp_j.ar_ready} !== 3'b000) begin
            bad++; $display("FAIL jit_rst_state got busy/vld/rdy=%b exp=000", {busy_j, mst_req_j.ar_valid, slv_resp_j.ar_ready});
        end
        step(); rst_j = 1'b0; req_j.ar_valid = 1'b0; sample();
        total++;
        if ({busy_j, mst_req_j.ar_valid, slv_resp_j.ar_ready} !== 3'b001) begin
            bad++; $display("FAIL jit_post_rst got busy/vld/rdy=%b exp=001", {busy_j, mst_req_j.ar_valid, slv_resp_j.ar_ready});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_delay0();
        test_pipeline();
        test_backpressure();
        test_delay_change();
        test_max_delay(32'h8000_0100);
        test_max_delay(32'h8000_0200);
        test_jitter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_latency_shaper.md
Name: axi_latency_shaper

Overview:
- Next-generation AXI channel delayer for verification benches and latency-sensitivity studies in the AXI IP library.
- Sits between an AXI master (slave port) and an AXI slave (master port).
- Each of the five channels has its own Depth-entry buffer. Every accepted beat is released exactly a run-time-programmable number of cycles after acceptance.
- Channels stay fully pipelined: up to Depth beats in flight per channel. An optional LFSR jitter adds random extra delay.

Parameters:
- aw_chan_t, w_chan_t, b_chan_t, ar_chan_t, r_chan_t: logic; AXI channel payload struct types.
- req_t, resp_t: logic; AXI request and response struct types.
- Depth: 4; entries per channel buffer, ≥1.
- DelayWidth: 8; width of the delay configuration inputs, ≥1.
- JitterIn: 0; enables random extra stall on AW/W/AR outputs.
- JitterOut: 0; enables random extra stall on B/R outputs.
- LfsrSeed: 16'hACE1; non-zero reset seed of the shared 16-bit LFSR.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- delay_in_i  in  DelayWidth  delay applied to AW/W/AR beats.
- delay_out_i  in  DelayWidth  delay applied to B/R beats.
- slv_req_i  in  req_t  request from upstream master.
- slv_resp_o  out  resp_t  response to upstream master.
- mst_req_o  out  req_t  request to downstream slave.
- mst_resp_i  in  resp_t  response from downstream slave.
- busy_o  out  1  high while any channel buffer is non-empty.

Behaviour:
- Channel structure:
  - Identical per-channel engine, instantiated five times.
  - Request direction: AW, W, AR use delay_in_i and JitterIn.
  - Response direction: B, R use delay_out_i and JitterOut.
  - All non-handshake fields pass through inside the payload struct untouched.
- Counter:
  - Free-running cycle counter cnt, width DelayWidth+1. Wraps mod 2^(DelayWidth+1).
  - Resets to 0.
- Accept:
  - ready_o = !full && !rst_i. There is no fall-through: when full, ready_o stays low even if a pop happens in the same cycle.
  - On valid_i && ready_o, the engine writes payload, due = cnt + delay + 1 (mod 2^(DelayWidth+1)) and ripe = 0 at the tail.
  - The delay value is sampled at acceptance. Later changes to the delay input do not affect beats already in flight.
- Ripening:
  - Each cycle, every occupied entry with cnt == due sets its sticky ripe bit.
  - The head is releasable when occupied && (ripe || cnt == due).
  - A beat accepted in cycle t is releasable at cycle t+1+delay at the earliest. Minimum latency is 1 (delay = 0). Maximum delay is 2^DelayWidth cycles.
  - No aliasing: the counter width guarantees due is reached before wrap.
- Release:
  - valid_o goes high when the head is releasable and the jitter gate passes.
  - Jitter gate: when jitter is disabled, it is always 1. When enabled, it is LFSR bit k, where k = channel index 0..4 for AW, W, B, AR, R.
  - Once valid_o is high it holds, with stable payload, until ready_i. This uses a per-channel presented flag, and jitter is never re-evaluated while presented.
  - On valid_o && ready_i the head pops and the presented flag clears.
- Ordering: strict FIFO per channel. There is no cross-channel ordering: W may overtake AW if the delays differ.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11. Advances every cycle. Resets to LfsrSeed.
- Simultaneous push and pop: both happen; occupancy is unchanged.
- Reset state (rst_i high, takes effect at the next edge):
  - All buffers are emptied, ripe bits and presented flags clear, cnt = 0.
  - All valid outputs are 0 and all ready outputs are 0 while rst_i is high.
  - busy_o = 0.
  - Reset mid-operation discards in-flight beats silently.
- Empty buffer: valid_o = 0.
- Full buffer: ready_o = 0.

Test Plan:
- Delay 0, no jitter: single AW accepted at cycle 10 → mst aw_valid at cycle 11, payload identical; busy_o high cycles 11 until handshake.
- delay_in_i = 5, four back-to-back W beats at cycles 20–23, downstream always ready → w_valid cycles 26–29, data in order, w_ready stays high throughout (Depth = 4).
- Depth = 4, downstream w_ready held 0 → fifth W beat sees w_ready = 0. Raise ready → one beat per cycle, and w_ready returns only the cycle after the first pop.
- delay_out_i changed 3 → 10 while two R beats in flight → those beats release at acceptance+4; beats accepted after the change release at acceptance+11.
- delay_in_i = 255 with DelayWidth = 8 → release exactly 256 cycles after acceptance. No early release across a counter wrap.
- JitterIn = 1, 1000 random AR beats with random ready → no beat earlier than delay+1, valid never drops before handshake, payload stable. Assert rst_i mid-stream → all valids and readys 0 next cycle, busy_o = 0.
